gpu_vram_rd_arbiter: RTL

Shares the single VRAM read command port between up to four read requesters: the VRAM→CPU copy state machine, the VRAM→VRAM copy engine, the CLUT loader and the texture cache. It arbitrates round-robin with optional burst locking and tracks outstanding reads in an in-order tag FIFO. Each returning read ACK and its data are routed back to the requester that issued the read. It sits between the GPU command state machines and the memory system's read port.

---
 rtl/gpu_vram_rd_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gpu_vram_rd_arbiter.sv
// VRAM read-port arbiter: round-robin grant with burst locking, registered
// memory command stage, in-order tag FIFO routing read ACKs/data back to the
// requester that issued each read.
module gpu_vram_rd_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_lock,
  input  logic [NREQ*ADDR_W-1:0]   i_addr,
  output logic [NREQ-1:0]          o_gnt,
  output logic [NREQ-1:0]          o_ack,
  output logic [31:0]              o_rdata,
  output logic                     o_memReq,
  output logic [ADDR_W-1:0]        o_memAddr,
  input  logic                     i_memBusy,
  input  logic                     i_memAck,
  input  logic [31:0]              i_memData,
  output logic [$clog2(DEPTH):0]   o_outstanding,
  output logic                     o_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {ST_FREE, ST_OWNED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic [IDX_W-1:0]   tag_mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               memReq_q;
  logic [ADDR_W-1:0]  memAddr_q;
  logic [NREQ-1:0]    ack_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic               lock_held;
  logic               stall;
  logic               can_grant;
  logic               rr_hit;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   cand;
  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic               push;
  logic               pop;

  // Requester index increment, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (int'(v) == NREQ - 1) return '0;
    else return v + IDX_W'(1);
  endfunction

  // Owner keeps exclusivity only while it holds its lock; a stalled command
  // blocks new grants. Reset also blocks grants so o_gnt reads 0 in reset.
  assign lock_held = (state_q == ST_OWNED) && i_lock[owner_q];
  assign stall     = memReq_q && i_memBusy;
  assign can_grant = !rst && !i_memBusy && !stall && (cnt_q < FULL_CNT);
  assign push      = gnt_any;
  assign pop       = i_memAck && (cnt_q != '0);

  // State register: arbitration state, owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FREE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Next state: drop ownership when the owner releases its lock, advance the
  // pointer past every granted index, take ownership on a locked grant.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if ((state_q == ST_OWNED) && !i_lock[owner_q]) state_d = ST_FREE;
    if (gnt_any) begin
      rr_d = wrap_inc(gnt_idx);
      if (!lock_held && i_lock[gnt_idx]) begin
        state_d = ST_OWNED;
        owner_d = gnt_idx;
      end
    end
  end

  // Output: first requester at/after rr_q wins, unless a held lock pins the owner.
  always_comb begin
    rr_hit  = 1'b0;
    rr_idx  = '0;
    cand    = rr_q;
    gnt_any = 1'b0;
    gnt_idx = '0;
    o_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_hit && i_req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
      cand = wrap_inc(cand);
    end
    if (can_grant) begin
      if (lock_held) begin
        gnt_any = i_req[owner_q];
        gnt_idx = owner_q;
      end else begin
        gnt_any = rr_hit;
        gnt_idx = rr_idx;
      end
    end
    if (gnt_any) o_gnt[gnt_idx] = 1'b1;
  end

  // Tag FIFO storage: granted requester index, read back in issue order.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_q] <= gnt_idx;
  end

  // Tag FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Command stage: load on grant, hold while memory is busy, otherwise idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
    end else if (gnt_any) begin
      memReq_q  <= 1'b1;
      memAddr_q <= i_addr[gnt_idx*ADDR_W +: ADDR_W];
    end else if (!stall) begin
      memReq_q  <= 1'b0;
    end
  end

  // Return path: one-cycle ACK pulse to the oldest tag; stray ACKs set sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      if (pop) begin
        ack_q[tag_mem_q[rd_q]] <= 1'b1;
        rdata_q                <= i_memData;
      end
      if (i_memAck && (cnt_q == '0)) err_q <= 1'b1;
    end
  end

  assign o_ack         = ack_q;
  assign o_rdata       = rdata_q;
  assign o_memReq      = memReq_q;
  assign o_memAddr     = memAddr_q;
  assign o_outstanding = cnt_q;
  assign o_err         = err_q;

endmodule
